// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and baud divider arithmetic.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Clocks per oversample tick; never below one so the tick generator always runs.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        int unsigned q;
        q = clk_freq / (baud_rate * oversample);
        if (q == 0) begin
            q = 1;
        end
        return q;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running divider producing the oversampling tick for TX and RX.
// Latency: tick is high for one clk every DIV clks, counter starts at 0 when enable rises.
// Backpressure: none; counter is held at 0 while enable is low.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter: wraps at DIV-1, parked at zero when the block is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == DIV_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == DIV_LAST);

endmodule

// File: rtl/uart_core.sv
// uart_core: UART TX + RX on one oversampling tick; parity bit compiled in with UART_PARITY_EN.
// Latency: tx_busy one clk after accepted tx_start; rx_valid on the clk after the stop-bit mid-sample.
// Backpressure: none; tx_start is dropped unless TX is idle, rx_valid/err flags are one-clk pulses.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    // Wide enough for two stop bits worth of ticks.
    localparam int TCW = $clog2(2 * OVERSAMPLE);
    localparam logic [TCW-1:0] OS_LAST   = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] STOP_LAST = TCW'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 1);

    logic tick;

    uart_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    // ------------------------------------------------------------------ TX
    uart_state_t          tx_state, tx_state_nxt;
    logic [TCW-1:0]       tx_tcnt, tx_tcnt_nxt;
    logic [3:0]           tx_bidx, tx_bidx_nxt;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
    logic                 tx_par, tx_par_nxt;
    logic                 tx_out_nxt, tx_done_nxt;

    // TX state and registered line/done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_tcnt  <= '0;
            tx_bidx  <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_out   <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_tcnt  <= tx_tcnt_nxt;
            tx_bidx  <= tx_bidx_nxt;
            tx_shift <= tx_shift_nxt;
            tx_par   <= tx_par_nxt;
            tx_out   <= tx_out_nxt;
            tx_done  <= tx_done_nxt;
        end
    end

    // TX sequencing; the line value is decoded from the next state so tx_out is glitch-free.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_tcnt_nxt  = tx_tcnt;
        tx_bidx_nxt  = tx_bidx;
        tx_shift_nxt = tx_shift;
        tx_par_nxt   = tx_par;
        tx_done_nxt  = 1'b0;
        tx_out_nxt   = 1'b1;
        if (!enable) begin
            tx_state_nxt = ST_IDLE;
            tx_tcnt_nxt  = '0;
            tx_bidx_nxt  = '0;
        end else begin
            unique case (tx_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        tx_state_nxt = ST_START;
                        tx_shift_nxt = tx_data;
                        tx_par_nxt   = (^tx_data) ^ PAR_ODD;
                        tx_tcnt_nxt  = '0;
                        tx_bidx_nxt  = '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (tx_tcnt == OS_LAST) begin
                            tx_tcnt_nxt  = '0;
                            tx_state_nxt = ST_DATA;
                        end else begin
                            tx_tcnt_nxt = tx_tcnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (tx_tcnt == OS_LAST) begin
                            tx_tcnt_nxt  = '0;
                            tx_shift_nxt = tx_shift >> 1;
                            if (tx_bidx == BIT_LAST) begin
                                tx_bidx_nxt = '0;
                                if (PAR_EN) tx_state_nxt = ST_PARITY;
                                else        tx_state_nxt = ST_STOP;
                            end else begin
                                tx_bidx_nxt = tx_bidx + 1'b1;
                            end
                        end else begin
                            tx_tcnt_nxt = tx_tcnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (tx_tcnt == OS_LAST) begin
                            tx_tcnt_nxt  = '0;
                            tx_state_nxt = ST_STOP;
                        end else begin
                            tx_tcnt_nxt = tx_tcnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (tx_tcnt == STOP_LAST) begin
                            tx_tcnt_nxt  = '0;
                            tx_state_nxt = ST_IDLE;
                            tx_done_nxt  = 1'b1;
                        end else begin
                            tx_tcnt_nxt = tx_tcnt + 1'b1;
                        end
                    end
                end
                default: tx_state_nxt = ST_IDLE;
            endcase
        end
        unique case (tx_state_nxt)
            ST_START:  tx_out_nxt = 1'b0;
            ST_DATA:   tx_out_nxt = tx_shift_nxt[0];
            ST_PARITY: tx_out_nxt = tx_par_nxt;
            default:   tx_out_nxt = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state != ST_IDLE);

    // ------------------------------------------------------------------ RX
    logic rx_meta, rx_sync, rx_prev;

    // Two-flop synchroniser plus one delay flop for falling-edge detection; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {rx_prev, rx_sync, rx_meta} <= 3'b111;
        end else begin
            {rx_prev, rx_sync, rx_meta} <= {rx_sync, rx_meta, rx_in};
        end
    end

    uart_state_t          rx_state, rx_state_nxt;
    logic [TCW-1:0]       rx_tcnt, rx_tcnt_nxt;
    logic [3:0]           rx_bidx, rx_bidx_nxt;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
    logic                 rx_par_bad, rx_par_bad_nxt;
    logic [DATA_BITS-1:0] rx_data_nxt;
    logic                 rx_valid_nxt, rx_ferr_nxt, rx_perr_nxt;

    // RX state and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state      <= ST_IDLE;
            rx_tcnt       <= '0;
            rx_bidx       <= '0;
            rx_shift      <= '0;
            rx_par_bad    <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_state      <= rx_state_nxt;
            rx_tcnt       <= rx_tcnt_nxt;
            rx_bidx       <= rx_bidx_nxt;
            rx_shift      <= rx_shift_nxt;
            rx_par_bad    <= rx_par_bad_nxt;
            rx_data       <= rx_data_nxt;
            rx_valid      <= rx_valid_nxt;
            rx_frame_err  <= rx_ferr_nxt;
            rx_parity_err <= rx_perr_nxt;
        end
    end

    // RX sequencing: half-bit start recheck, then one sample per bit at mid-point.
    always_comb begin
        rx_state_nxt   = rx_state;
        rx_tcnt_nxt    = rx_tcnt;
        rx_bidx_nxt    = rx_bidx;
        rx_shift_nxt   = rx_shift;
        rx_par_bad_nxt = rx_par_bad;
        rx_data_nxt    = rx_data;
        rx_valid_nxt   = 1'b0;
        rx_ferr_nxt    = 1'b0;
        rx_perr_nxt    = 1'b0;
        if (!enable) begin
            rx_state_nxt = ST_IDLE;
            rx_tcnt_nxt  = '0;
            rx_bidx_nxt  = '0;
        end else begin
            unique case (rx_state)
                ST_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state_nxt   = ST_START;
                        rx_tcnt_nxt    = '0;
                        rx_bidx_nxt    = '0;
                        rx_par_bad_nxt = 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_tcnt == HALF_LAST) begin
                            rx_tcnt_nxt = '0;
                            // A line already back high was a glitch, not a start bit.
                            if (rx_sync) rx_state_nxt = ST_IDLE;
                            else         rx_state_nxt = ST_DATA;
                        end else begin
                            rx_tcnt_nxt = rx_tcnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (rx_tcnt == OS_LAST) begin
                            rx_tcnt_nxt  = '0;
                            rx_shift_nxt = {rx_sync, rx_shift[DATA_BITS-1:1]};
                            if (rx_bidx == BIT_LAST) begin
                                rx_bidx_nxt = '0;
                                if (PAR_EN) rx_state_nxt = ST_PARITY;
                                else        rx_state_nxt = ST_STOP;
                            end else begin
                                rx_bidx_nxt = rx_bidx + 1'b1;
                            end
                        end else begin
                            rx_tcnt_nxt = rx_tcnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (rx_tcnt == OS_LAST) begin
                            rx_tcnt_nxt    = '0;
                            rx_par_bad_nxt = (^rx_shift) ^ rx_sync ^ PAR_ODD;
                            rx_state_nxt   = ST_STOP;
                        end else begin
                            rx_tcnt_nxt = rx_tcnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (rx_tcnt == OS_LAST) begin
                            rx_tcnt_nxt  = '0;
                            rx_state_nxt = ST_IDLE;
                            rx_data_nxt  = rx_shift;
                            rx_valid_nxt = 1'b1;
                            rx_ferr_nxt  = !rx_sync;
                            rx_perr_nxt  = PAR_EN & rx_par_bad;
                        end else begin
                            rx_tcnt_nxt = rx_tcnt + 1'b1;
                        end
                    end
                end
                default: rx_state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600: line bit rate.
REQ-003 Parameter OVERSAMPLE, default 16: ticks per bit, power of two, 8..16.
REQ-004 Parameter DATA_BITS, default 8: payload width, 5..9.
REQ-005 Parameter STOP_BITS, default 1: transmitted stop bits, 1 or 2.
REQ-006 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when the parity feature is compiled in.
REQ-007 clk  in  1  single clock for the whole block.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 enable  in  1  high = TX and RX operate; low = both return to IDLE at the next clk edge.
REQ-010 tx_start  in  1  one-cycle request to send tx_data.
REQ-011 tx_data  in  DATA_BITS  payload to transmit.
REQ-012 tx_out  out  1  serial TX line, idle high.
REQ-013 tx_busy  out  1  high while a frame is in flight.
REQ-014 tx_done  out  1  one-cycle pulse at the end of the last stop bit.
REQ-015 rx_in  in  1  asynchronous serial RX line.
REQ-016 rx_data  out  DATA_BITS  last received payload, held until the next valid frame.
REQ-017 rx_valid  out  1  one-cycle pulse when rx_data updates.
REQ-018 rx_frame_err  out  1  one-cycle pulse, coincident with rx_valid, when the sampled stop bit is 0.
REQ-019 rx_parity_err  out  1  one-cycle pulse, coincident with rx_valid, on a parity mismatch.

Function
REQ-020 Tick generator: one-clk tick every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks (integer division); the counter wraps from DIV-1 to 0 and is free-running while enable is high.
REQ-021 TX FSM: states IDLE, START, DATA, PARITY, STOP; each bit lasts exactly OVERSAMPLE ticks; data is sent LSB first.
REQ-022 TX accepts tx_start only in IDLE with enable high; tx_data is captured on that edge and tx_busy rises on the next cycle.
REQ-023 tx_start while tx_busy is high is ignored; the current frame is not disturbed.
REQ-024 TX STOP lasts STOP_BITS*OVERSAMPLE ticks, then tx_done pulses, the FSM goes to IDLE and tx_busy falls on the same edge.
REQ-025 RX input passes through a 2-flop synchroniser before any use.
REQ-026 RX FSM: states IDLE, START, DATA, PARITY, STOP.
REQ-027 RX leaves IDLE on a synchronised falling edge and rechecks the line at tick OVERSAMPLE/2-1; if the line is high (glitch), RX returns to IDLE with no outputs.
REQ-028 RX samples each subsequent bit at its mid-point, exactly OVERSAMPLE ticks apart, and assembles the payload LSB first.
REQ-029 RX checks one stop bit only; at the stop-bit sample it updates rx_data, pulses rx_valid plus any error flag, and returns to IDLE.
REQ-030 On a frame error, rx_data is still updated.
REQ-031 Simultaneous TX and RX activity is fully independent.
REQ-032 Falling enable mid-frame forces tx_out high and both FSMs to IDLE, with no rx_valid and no tx_done.

Reset
REQ-033 rst high asynchronously sets: tx_out=1, tx_busy=0, tx_done=0, rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0, both FSMs=IDLE, all counters=0, synchroniser flops=1.
REQ-034 A reset asserted mid-frame aborts the frame; after release the block waits in IDLE for a new start.

Configuration
REQ-035 Macro UART_PARITY_EN defined: one parity bit, computed per PARITY_ODD, is sent and checked in the PARITY state, between DATA and STOP.
REQ-036 Macro UART_PARITY_EN undefined: the PARITY state is skipped and rx_parity_err is tied to 0.

Structure
REQ-037 Package uart_pkg holds the shared FSM state enumeration (uart_state_t) and the DIV computation function.
REQ-038 Sub-module uart_tick_gen implements REQ-020; the TX and RX FSMs stay in uart_core.

Verification
Bench parameters for all scenarios: CLK_FREQ=7372800, BAUD_RATE=115200, OVERSAMPLE=16, so DIV=4 and one bit = 64 clk.
REQ-039 TX 8N1: tx_start with tx_data=8'hA5 -> tx_out shows 0,1,0,1,0,0,1,0,1,1 (64 clk per bit), tx_busy high for 640 clk, then one tx_done pulse.
REQ-040 RX loopback: tx_out tied to rx_in, send 8'h3C -> rx_valid pulses once with rx_data=8'h3C and no error flags.
REQ-041 Frame error: drive the 8'h55 frame with a stop bit of 0 -> rx_valid and rx_frame_err pulse together, rx_data=8'h55.
REQ-042 Glitch and busy: a 20-clk low pulse on rx_in -> no rx_valid; tx_start during tx_busy -> frame unchanged, a single tx_done.
REQ-043 With UART_PARITY_EN and PARITY_ODD=0: send 8'h07 -> parity bit 1 is sent; flip that bit on the RX side -> rx_parity_err pulses.
REQ-044 Reset mid-frame: assert rst at bit 4 of a TX frame -> tx_out=1 and tx_busy=0 immediately; the next tx_start sends a full correct frame.
